gmii_frame_gen: RTL

Synthesizable GMII frame generator for hardware and simulation test benches, sitting where the file/TAP packet source drives `vgmii_rxd`/`vgmii_rx_dv` of the Ethernet core. A frame payload is loaded into an internal byte buffer, and the block replays it on request. Each frame gets preamble and SFD, optional zero-padding to Ethernet minimum length, and an optional computed FCS. It supports repeat count, programmable inter-frame gap, and a `hold` throttle that ties to the core's `in_use` so that new frames start only while the core is idle.

---
 rtl/gmii_frame_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gmii_frame_gen.sv
// GMII frame generator: replays a buffered payload as preamble/SFD/data/pad/FCS
// frames with a programmable repeat count, inter-frame gap and hold throttle.
module gmii_frame_gen #(
    parameter int aw      = 11,
    parameter int pre_len = 7,
    parameter int ifg     = 12,
    parameter int add_fcs = 1,
    parameter int pad_en  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [aw-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic [aw:0]   len,
    input  logic [7:0]    count,
    input  logic          hold,
    output logic [7:0]    txd,
    output logic          tx_en,
    output logic          busy,
    output logic          done,
    output logic [15:0]   frames_sent
);

    typedef enum logic [2:0] {IDLE, WAIT, PRE, SFD, DATA, PAD, FCS, GAP} state_t;

    logic [7:0]    mem [0:(1<<aw)-1];
    logic [aw-1:0] rd_addr;
    logic [7:0]    rd_byte_p0;
    logic [aw:0]   idx;
    logic [aw:0]   len_q;
    logic [7:0]    remaining;
    logic [11:0]   cnt;
    logic [31:0]   crc;
    state_t        state;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] sel);
        logic [31:0] inv;
        inv = ~c;
        return inv[8*sel +: 8];
    endfunction

    // Buffer read stage: SFD fetches byte 0 so DATA always holds the byte it emits
    always_comb begin
        rd_addr = '0;
        if (state == DATA)
            rd_addr = idx[aw-1:0] + aw'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_byte_p0 <= mem[rd_addr];
    end

    // Control FSM with output register stage one cycle behind the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            txd         <= 8'h00;
            tx_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= 16'h0000;
            len_q       <= '0;
            remaining   <= 8'h00;
            crc         <= 32'h0;
            idx         <= '0;
            cnt         <= 12'h000;
        end else begin
            busy  <= (state != IDLE);
            done  <= (state == IDLE) && busy;
            tx_en <= state inside {PRE, SFD, DATA, PAD, FCS};
            case (state)
                PRE:     txd <= 8'h55;
                SFD:     txd <= 8'hD5;
                DATA:    txd <= rd_byte_p0;
                FCS:     txd <= fcs_byte(crc, cnt[1:0]);
                default: txd <= 8'h00;
            endcase

            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        len_q     <= len;
                        remaining <= (count == 8'h00) ? 8'h01 : count;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!hold) begin
                        cnt   <= 12'h000;
                        state <= PRE;
                    end
                end
                PRE: begin
                    crc <= 32'hFFFFFFFF;
                    if (cnt == 12'(pre_len - 1))
                        state <= SFD;
                    else
                        cnt <= cnt + 12'd1;
                end
                SFD: begin
                    idx   <= '0;
                    state <= DATA;
                end
                DATA: begin
                    crc <= crc32_byte(crc, rd_byte_p0);
                    idx <= idx + (aw+1)'(1);
                    if (idx == len_q - (aw+1)'(1)) begin
                        cnt <= 12'h000;
                        if (pad_en != 0 && len_q < (aw+1)'(60))
                            state <= PAD;
                        else if (add_fcs != 0)
                            state <= FCS;
                        else
                            state <= GAP;
                    end
                end
                PAD: begin
                    crc <= crc32_byte(crc, 8'h00);
                    idx <= idx + (aw+1)'(1);
                    if (idx == (aw+1)'(59)) begin
                        cnt   <= 12'h000;
                        state <= (add_fcs != 0) ? FCS : GAP;
                    end
                end
                FCS: begin
                    if (cnt == 12'd3) begin
                        cnt   <= 12'h000;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                GAP: begin
                    // Last gap cycle doubles as the hold check so back-to-back frames see exactly ifg idles
                    if (cnt == 12'(ifg - 1)) begin
                        cnt         <= 12'h000;
                        frames_sent <= frames_sent + 16'd1;
                        remaining   <= remaining - 8'd1;
                        if (remaining == 8'd1)
                            state <= IDLE;
                        else if (hold)
                            state <= WAIT;
                        else
                            state <= PRE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
